// File: rtl/mio_bus_ctrl.sv
// mio_bus_ctrl: CPU data-bus controller decoding RAM, GPIO and cycle-counter targets.
// Single-outstanding request FSM with registered RAM strobes and a RESP-cycle ready pulse.
module mio_bus_ctrl #(
    parameter int RAM_AW = 10,
    parameter int WAIT_STATES = 1,
    parameter int GPIO_W = 16,
    parameter logic [GPIO_W-1:0] LED_RESET = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_mio,
    input  logic              cpu_mwr,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_dout,
    output logic [31:0]       cpu_din,
    output logic              cpu_ready,
    output logic              ram_en,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    input  logic [GPIO_W-1:0] sw_in,
    output logic [GPIO_W-1:0] led_out,
    output logic              bus_err
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
    localparam logic [2:0] RG_RAM = 3'd0, RG_LED = 3'd1, RG_SW = 3'd2, RG_CNT = 3'd3, RG_UNM = 3'd4;
    localparam int WW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam logic [WW-1:0] W_LOAD = WW'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    state_t              r_state;
    logic [2:0]          r_region;
    logic                r_mwr;
    logic [RAM_AW-1:0]   r_waddr;
    logic [31:0]         r_dout;
    logic [WW-1:0]       r_wcnt;
    logic [GPIO_W-1:0]   r_led;
    logic [GPIO_W-1:0]   r_sync1;
    logic [GPIO_W-1:0]   r_sync2;
    logic [31:0]         r_cnt;
    logic                r_err;
    logic                r_ram_en;
    logic                r_ram_we;
    logic                r_ready;
    logic [2:0]          w_region;
    logic [31:0]         w_rdata;
    logic                w_unused;

    always_comb begin
        w_region = (cpu_addr[31:28] == 4'h0) ? RG_RAM :
                   (cpu_addr[31:28] == 4'hE) ? RG_LED :
                   (cpu_addr[31:28] == 4'hF) ? (cpu_addr[2] ? RG_CNT : RG_SW) : RG_UNM;
        w_rdata  = (r_region == RG_RAM) ? ram_rdata :
                   (r_region == RG_LED) ? 32'(r_led) :
                   (r_region == RG_SW)  ? 32'(r_sync2) :
                   (r_region == RG_CNT) ? r_cnt : 32'd0;
    end

    assign w_unused  = ^{cpu_addr[27:RAM_AW+2], cpu_addr[1:0]};
    assign cpu_din   = (r_state == RESP && !r_mwr) ? w_rdata : 32'd0;
    assign cpu_ready = r_ready;
    assign ram_en    = r_ram_en;
    assign ram_we    = r_ram_we;
    assign ram_addr  = r_waddr;
    assign ram_wdata = r_dout;
    assign led_out   = r_led;
    assign bus_err   = r_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_region <= RG_UNM;
            r_mwr    <= 1'b0;
            r_waddr  <= '0;
            r_dout   <= '0;
            r_wcnt   <= '0;
            r_led    <= LED_RESET;
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
            r_ram_en <= 1'b0;
            r_ram_we <= 1'b0;
            r_ready  <= 1'b0;
        end else begin
            r_sync1  <= sw_in;
            r_sync2  <= r_sync1;
            r_cnt    <= r_cnt + 32'd1;
            r_ram_en <= 1'b0;
            r_ram_we <= 1'b0;
            r_ready  <= 1'b0;
            case (r_state)
                IDLE: if (cpu_mio) begin
                    r_state  <= ACCESS;
                    r_region <= w_region;
                    r_mwr    <= cpu_mwr;
                    r_waddr  <= cpu_addr[RAM_AW+1:2];
                    r_dout   <= cpu_dout;
                    r_ram_en <= (w_region == RG_RAM);
                    r_ram_we <= (w_region == RG_RAM) && cpu_mwr;
                end
                ACCESS: begin
                    if (r_mwr && r_region == RG_LED) r_led <= r_dout[GPIO_W-1:0];
                    // a counter load overrides this edge's increment
                    if (r_mwr && r_region == RG_CNT) r_cnt <= r_dout;
                    if (r_region == RG_UNM) r_err <= 1'b1;
                    if (WAIT_STATES > 0 && r_region == RG_RAM) begin
                        r_state <= WAIT;
                        r_wcnt  <= W_LOAD;
                    end else begin
                        r_state <= RESP;
                        r_ready <= 1'b1;
                    end
                end
                WAIT: if (r_wcnt == '0) begin
                    r_state <= RESP;
                    r_ready <= 1'b1;
                end else begin
                    r_wcnt <= r_wcnt - 1'b1;
                end
                RESP: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mio_bus_ctrl.sv
// tb_mio_bus_ctrl: directed plus random transactions against a transaction-level model
// that predicts each cycle's outputs from access/response cycle numbers.
module tb_mio_bus_ctrl;
    localparam int WS = 1;
    localparam int AW = 10;
    localparam int GW = 16;
    localparam int RAM = 0, LED = 1, SW = 2, CNT = 3, UNM = 4;

    logic          clk = 0;
    logic          reset;
    logic          cpu_mio, cpu_mwr;
    logic [31:0]   cpu_addr, cpu_dout, cpu_din;
    logic          cpu_ready, ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata, ram_rdata;
    logic [GW-1:0] sw_in, led_out;
    logic          bus_err;

    mio_bus_ctrl #(.RAM_AW(AW), .WAIT_STATES(WS), .GPIO_W(GW), .LED_RESET('0)) dut (
        .clk(clk), .reset(reset), .cpu_mio(cpu_mio), .cpu_mwr(cpu_mwr),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_din(cpu_din), .cpu_ready(cpu_ready),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .sw_in(sw_in), .led_out(led_out), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    logic [31:0] ram_mem [1<<AW];
    always @(posedge clk) if (ram_en) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        else ram_rdata <= ram_mem[ram_addr];
    end

    int n_pass = 0, n_total = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // transaction-level model: one outstanding access, described by its access and response cycles
    int          cyc = 0, t_acc = 0, t_resp = 0, t_reg = 0, cnt_cyc = 0;
    bit          busy = 0, t_w = 0, m_err = 0;
    logic [31:0] t_addr = 0, t_data = 0, cnt_base = 0;
    logic [GW-1:0] m_led = 0, sw_d1 = 0, sw_d2 = 0;
    logic [31:0] m_mem [1<<AW];

    function automatic int region(input logic [31:0] a);
        case (a[31:28])
            4'h0: return RAM;
            4'hE: return LED;
            4'hF: return a[2] ? CNT : SW;
            default: return UNM;
        endcase
    endfunction

    function automatic logic [31:0] mread();
        case (t_reg)
            RAM: return m_mem[t_addr[AW+1:2]];
            LED: return 32'(m_led);
            SW:  return 32'(sw_d2);
            CNT: return cnt_base + 32'(cyc - cnt_cyc);
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc = 0; busy = 0; m_led = 0; m_err = 0; sw_d1 = 0; sw_d2 = 0;
            cnt_base = 0; cnt_cyc = 0;
        end else begin
            cyc++;
            sw_d2 = sw_d1;
            sw_d1 = sw_in;
            if (busy && cyc == t_acc + 1) begin
                if (t_w && t_reg == RAM) m_mem[t_addr[AW+1:2]] = t_data;
                if (t_w && t_reg == LED) m_led = t_data[GW-1:0];
                if (t_w && t_reg == CNT) begin cnt_base = t_data; cnt_cyc = cyc; end
                if (t_reg == UNM) m_err = 1;
            end
            if (busy && cyc == t_resp + 1) busy = 0;
            else if (!busy && cpu_mio) begin
                busy = 1; t_w = cpu_mwr; t_addr = cpu_addr; t_data = cpu_dout;
                t_reg = region(cpu_addr); t_acc = cyc;
                t_resp = cyc + 1 + ((t_reg == RAM) ? WS : 0);
            end
        end
    end

    always @(negedge clk) if (!reset) begin
        bit e_en, e_rdy;
        e_en  = busy && cyc == t_acc && t_reg == RAM;
        e_rdy = busy && cyc == t_resp;
        chk("ready", 32'(cpu_ready), 32'(e_rdy));
        chk("din", cpu_din, (e_rdy && !t_w) ? mread() : 32'd0);
        chk("ram_en", 32'(ram_en), 32'(e_en));
        chk("ram_we", 32'(ram_we), 32'(e_en && t_w));
        chk("led", 32'(led_out), 32'(m_led));
        chk("bus_err", 32'(bus_err), 32'(m_err));
        if (e_en) begin
            chk("ram_addr", 32'(ram_addr), 32'(t_addr[AW+1:2]));
            if (t_w) chk("ram_wdata", ram_wdata, t_data);
        end
    end

    int we_cnt = 0;
    logic [AW-1:0] we_addr = 0;
    always @(negedge clk) if (!reset && ram_we) begin we_cnt++; we_addr = ram_addr; end

    bit rnd = 0;
    task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] din, output int lat);
        @(negedge clk);
        cpu_mio = 1; cpu_mwr = w; cpu_addr = a; cpu_dout = d;
        @(posedge clk);
        @(negedge clk);
        cpu_mio = rnd ? 1'($urandom) : 1'b0;
        cpu_mwr = 1'($urandom); cpu_addr = $urandom; cpu_dout = $urandom;
        lat = 0; din = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (rnd && $urandom_range(3) == 0) sw_in = GW'($urandom);
            if (cpu_ready) begin din = cpu_din; break; end
        end
        if (lat == 20) chk("ready_timeout", 32'(cpu_ready), 32'd1);
        cpu_mio = 0;
    endtask

    initial begin
        logic [31:0] d, a, r;
        int l;
        reset = 1; cpu_mio = 0; cpu_mwr = 0; cpu_addr = 0; cpu_dout = 0; sw_in = 0;
        for (int i = 0; i < (1<<AW); i++) begin ram_mem[i] = 0; m_mem[i] = 0; end
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 0;
        chk("rst_led", 32'(led_out), 32'd0);
        chk("rst_err", 32'(bus_err), 32'd0);
        chk("rst_ready", 32'(cpu_ready), 32'd0);

        we_cnt = 0;
        xact(1, 32'h0000_0010, 32'hCAFE_BABE, d, l);
        chk("ramw_lat", 32'(l), 32'(1 + WS));
        chk("ramw_pulses", 32'(we_cnt), 32'd1);
        chk("ramw_addr", 32'(we_addr), 32'd4);
        xact(0, 32'h0000_0010, 32'h0, d, l);
        chk("ramr_din", d, 32'hCAFE_BABE);
        chk("ramr_lat", 32'(l), 32'(1 + WS));
        xact(0, 32'h0000_1010, 32'h0, d, l);
        chk("ram_alias", d, 32'hCAFE_BABE);

        xact(1, 32'hE000_0000, 32'h0000_A5A5, d, l);
        chk("ledw_lat", 32'(l), 32'd1);
        chk("ledw_val", 32'(led_out), 32'h0000_A5A5);
        xact(0, 32'hE000_0123, 32'h0, d, l);
        chk("ledr_din", d, 32'h0000_A5A5);

        sw_in = 16'h1234;
        repeat (3) @(negedge clk);
        xact(0, 32'hF000_0000, 32'h0, d, l);
        chk("sw_din", d, 32'h0000_1234);
        xact(1, 32'hF000_0000, 32'h0000_FFFF, d, l);
        chk("sww_err", 32'(bus_err), 32'd0);
        chk("sww_led", 32'(led_out), 32'h0000_A5A5);
        xact(0, 32'hF000_0008, 32'h0, d, l);
        chk("sw_din2", d, 32'h0000_1234);

        xact(1, 32'hF000_0004, 32'hFFFF_FFFE, d, l);
        xact(0, 32'hF000_0004, 32'h0, d, l);
        chk("cnt_wrap1", d, 32'h0000_0001);
        xact(0, 32'hF000_0004, 32'h0, d, l);
        chk("cnt_wrap2", d, 32'h0000_0004);

        xact(0, 32'h5000_0000, 32'h0, d, l);
        chk("unm_din", d, 32'h0);
        chk("unm_lat", 32'(l), 32'd1);
        chk("unm_err", 32'(bus_err), 32'd1);
        xact(0, 32'h0000_0010, 32'h0, d, l);
        chk("err_sticky", 32'(bus_err), 32'd1);

        rnd = 1;
        repeat (300) begin
            r = $urandom;
            a = $urandom;
            case (r[2:0])
                3'd0, 3'd1, 3'd2: a = {4'h0, a[27:6], 4'(r[7:4]), 2'b00};
                3'd3: a[31:28] = 4'hE;
                3'd4, 3'd5: a[31:28] = 4'hF;
                default: a[31:28] = 4'(1 + r[11:8] % 13);
            endcase
            repeat (r[13:12]) @(posedge clk);
            xact(r[16], a, $urandom, d, l);
        end
        rnd = 0;

        @(negedge clk);
        cpu_mio = 1; cpu_mwr = 1; cpu_addr = 32'h0000_0020; cpu_dout = 32'h1111_1111;
        @(posedge clk);
        @(negedge clk) cpu_mio = 0;
        @(posedge clk);
        #1 reset = 1;
        #1;
        chk("rst_mid_ready", 32'(cpu_ready), 32'd0);
        chk("rst_mid_we", 32'(ram_we), 32'd0);
        chk("rst_mid_en", 32'(ram_en), 32'd0);
        chk("rst_mid_led", 32'(led_out), 32'd0);
        chk("rst_mid_err", 32'(bus_err), 32'd0);
        repeat (2) @(negedge clk);
        reset = 0;
        xact(0, 32'h0000_0020, 32'h0, d, l);
        chk("post_rst_din", d, 32'h1111_1111);
        chk("post_rst_lat", 32'(l), 32'(1 + WS));
        chk("post_rst_err", 32'(bus_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
